// File: rtl/cnt_bcd_mod_if.sv
// cnt_bcd_mod_if: control and data bundle for one BCD modulo counter stage.
// The master side drives clear/enable/step/load/direction and observes the
// BCD digits and the terminal carry. DN exists only when CNT_BCD_DOWN_EN is
// defined.
interface cnt_bcd_mod_if;
    logic       CLR;
    logic       EN;
    logic       INC;
    logic       LD;
    logic [3:0] DH;
    logic [3:0] DL;
`ifdef CNT_BCD_DOWN_EN
    logic       DN;
`endif
    logic [3:0] QH;
    logic [3:0] QL;
    logic       CA;

`ifdef CNT_BCD_DOWN_EN
    modport master (
        output CLR, EN, INC, LD, DH, DL, DN,
        input  QH, QL, CA
    );
    modport slave (
        input  CLR, EN, INC, LD, DH, DL, DN,
        output QH, QL, CA
    );
`else
    modport master (
        output CLR, EN, INC, LD, DH, DL,
        input  QH, QL, CA
    );
    modport slave (
        input  CLR, EN, INC, LD, DH, DL,
        output QH, QL, CA
    );
`endif
endinterface

// File: rtl/cnt_bcd_mod.sv
// cnt_bcd_mod: two-digit BCD counter with modulus MOD (2..100), parallel
// load, manual single step and a zero-latency terminal carry for cascading.
// Optional macro CNT_BCD_DOWN_EN adds the DN direction input (down count,
// CA becomes a borrow at zero). Without it the counter counts up only.
module cnt_bcd_mod #(
    parameter int unsigned MOD     = 60,
    parameter int unsigned CA_GATE = 1
) (
    input  logic         CLK,
    input  logic         RST,
    cnt_bcd_mod_if.slave bus
);

    localparam int unsigned MAXV     = MOD - 1;
    localparam logic [3:0]  TERM_H   = 4'(MAXV / 10);
    localparam logic [3:0]  TERM_L   = 4'(MAXV % 10);
    localparam bit          HAS_TENS = (MOD > 10);
    localparam logic [7:0]  MOD_B    = 8'(MOD);

    logic [3:0] qh_q, ql_q;
    logic [3:0] qh_d, ql_d;

    logic       dn;
    logic       at_max;
    logic       at_zero;
    logic       term;
    logic       qual;
    logic       step;
    logic [7:0] ld_val;
    logic       ld_ok;
    logic [3:0] up_h, up_l;
    logic [3:0] dn_h, dn_l;

`ifdef CNT_BCD_DOWN_EN
    assign dn = bus.DN;
`else
    assign dn = 1'b0;
`endif

    assign at_max  = (qh_q == TERM_H) && (ql_q == TERM_L);
    assign at_zero = (qh_q == 4'd0) && (ql_q == 4'd0);
    assign term    = dn ? at_zero : at_max;
    assign qual    = (CA_GATE != 0) ? bus.EN : (bus.EN | bus.INC);
    assign step    = bus.EN | bus.INC;

    // Load value is only accepted when both digits are BCD and below MOD.
    assign ld_val = (8'(bus.DH) * 8'd10) + 8'(bus.DL);
    assign ld_ok  = (bus.DH <= 4'd9) && (bus.DL <= 4'd9) && (ld_val < MOD_B);

    // Carry is combinational so a cascaded stage steps on the same edge.
    assign bus.CA = term & qual & ~bus.LD & ~bus.CLR & ~RST;
    assign bus.QH = qh_q;
    assign bus.QL = ql_q;

    // Up neighbour of the current value, wrapping MOD-1 to 0.
    always_comb begin
        up_h = qh_q;
        up_l = ql_q;
        if (at_max) begin
            up_h = '0;
            up_l = '0;
        end else if (ql_q == 4'd9) begin
            up_h = qh_q + 4'd1;
            up_l = '0;
        end else begin
            up_l = ql_q + 4'd1;
        end
    end

    // Down neighbour of the current value, wrapping 0 to MOD-1.
    always_comb begin
        dn_h = qh_q;
        dn_l = ql_q;
        if (at_zero) begin
            dn_h = TERM_H;
            dn_l = TERM_L;
        end else if (ql_q == 4'd0) begin
            dn_h = qh_q - 4'd1;
            dn_l = 4'd9;
        end else begin
            dn_l = ql_q - 4'd1;
        end
    end

    // Next-state selection: clear > load > step > hold.
    always_comb begin
        qh_d = qh_q;
        ql_d = ql_q;
        if (bus.CLR) begin
            qh_d = '0;
            ql_d = '0;
        end else if (bus.LD) begin
            if (ld_ok) begin
                qh_d = bus.DH;
                ql_d = bus.DL;
            end else begin
                qh_d = '0;
                ql_d = '0;
            end
        end else if (step) begin
            if (dn) begin
                qh_d = dn_h;
                ql_d = dn_l;
            end else begin
                qh_d = up_h;
                ql_d = up_l;
            end
        end
        if (!HAS_TENS) begin
            qh_d = '0;
        end
    end

    // Digit registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            qh_q <= '0;
            ql_q <= '0;
        end else begin
            qh_q <= qh_d;
            ql_q <= ql_d;
        end
    end

    a_ql_bcd : assert property (@(posedge CLK) disable iff (RST) ql_q <= 4'd9);
    a_v_lt_mod : assert property (@(posedge CLK) disable iff (RST)
        ((8'(qh_q) * 8'd10) + 8'(ql_q)) < MOD_B);
    a_ca_quiet : assert property (@(posedge CLK) (RST || bus.CLR) |-> !bus.CA);

endmodule

// File: tb/tb_cnt_bcd_mod.sv
// tb_cnt_bcd_mod: scoreboard bench. A driver applies shared stimulus to five
// counters of different MOD/CA_GATE plus a cascaded 60x60 pair, pushing the
// expected observation per cycle; a monitor pops and compares at negedge.
module tb_cnt_bcd_mod;

    localparam int NDUT = 5;

    function automatic int unsigned mod_of(input int i);
        case (i)
            0: return 60;
            1: return 60;
            2: return 24;
            3: return 7;
            default: return 100;
        endcase
    endfunction

    function automatic int unsigned gate_of(input int i);
        case (i)
            0: return 1;
            1: return 0;
            2: return 1;
            3: return 1;
            default: return 0;
        endcase
    endfunction

`ifdef CNT_BCD_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       clr, en, inc, ld, dn;
    logic [3:0] dh, dl;

    logic [3:0] qh_a [NDUT];
    logic [3:0] ql_a [NDUT];
    logic       ca_a [NDUT];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        cnt_bcd_mod_if bus ();
        assign bus.CLR = clr;
        assign bus.EN  = en;
        assign bus.INC = inc;
        assign bus.LD  = ld;
        assign bus.DH  = dh;
        assign bus.DL  = dl;
`ifdef CNT_BCD_DOWN_EN
        assign bus.DN  = dn;
`endif
        assign qh_a[gi] = bus.QH;
        assign ql_a[gi] = bus.QL;
        assign ca_a[gi] = bus.CA;
        cnt_bcd_mod #(.MOD(mod_of(gi)), .CA_GATE(gate_of(gi))) dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus.slave)
        );
    end

    cnt_bcd_mod_if lo_if ();
    cnt_bcd_mod_if hi_if ();
    assign lo_if.CLR = clr;
    assign lo_if.EN  = en;
    assign lo_if.INC = 1'b0;
    assign lo_if.LD  = 1'b0;
    assign lo_if.DH  = 4'd0;
    assign lo_if.DL  = 4'd0;
    assign hi_if.CLR = clr;
    assign hi_if.EN  = lo_if.CA;
    assign hi_if.INC = 1'b0;
    assign hi_if.LD  = 1'b0;
    assign hi_if.DH  = 4'd0;
    assign hi_if.DL  = 4'd0;
`ifdef CNT_BCD_DOWN_EN
    assign lo_if.DN  = 1'b0;
    assign hi_if.DN  = 1'b0;
`endif

    cnt_bcd_mod #(.MOD(60), .CA_GATE(1)) u_lo (.CLK(clk), .RST(rst), .bus(lo_if.slave));
    cnt_bcd_mod #(.MOD(60), .CA_GATE(1)) u_hi (.CLK(clk), .RST(rst), .bus(hi_if.slave));

    typedef struct {
        int          id;
        int unsigned v;
        bit          ca;
        bit          ca2;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          hi_ca_cnt = 0;
    int unsigned v_m [NDUT];
    int unsigned c_m;

    task automatic chk(input string nm, input int id, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s dut=%0d t=%0t: got %0d required %0d", nm, id, $time, got, exp);
        end
    endtask

    // Monitor: compare every pending expectation against the DUT outputs.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.id < NDUT) begin
                chk("QH", e.id, int'(qh_a[e.id]), int'(e.v / 10));
                chk("QL", e.id, int'(ql_a[e.id]), int'(e.v % 10));
                chk("CA", e.id, int'(ca_a[e.id]), int'(e.ca));
            end else begin
                chk("LO_QH", e.id, int'(lo_if.QH), int'((e.v % 60) / 10));
                chk("LO_QL", e.id, int'(lo_if.QL), int'((e.v % 60) % 10));
                chk("HI_QH", e.id, int'(hi_if.QH), int'((e.v / 60) / 10));
                chk("HI_QL", e.id, int'(hi_if.QL), int'((e.v / 60) % 10));
                chk("LO_CA", e.id, int'(lo_if.CA), int'(e.ca));
                chk("HI_CA", e.id, int'(hi_if.CA), int'(e.ca2));
                if (hi_if.CA) hi_ca_cnt++;
            end
        end
    end

    // Apply one cycle of stimulus, record expectations, advance the models.
    task automatic cyc(input bit r, input bit c, input bit e, input bit i,
                       input bit l, input int h, input int lo, input bit d);
        exp_t x;
        rst = r; clr = c; en = e; inc = i; ld = l;
        dh = 4'(h); dl = 4'(lo); dn = d;
        for (int k = 0; k < NDUT; k++) begin
            int unsigned m;
            bit          down, term, qual;
            m    = mod_of(k);
            down = DOWN_EN && d;
            term = down ? (v_m[k] == 0) : (v_m[k] == m - 1);
            qual = (gate_of(k) != 0) ? e : (e | i);
            x.id = k; x.v = v_m[k]; x.ca = term && qual && !l && !c && !r; x.ca2 = 1'b0;
            sb.push_back(x);
            if (r || c) v_m[k] = 0;
            else if (l) v_m[k] = (h <= 9 && lo <= 9 && h * 10 + lo < int'(m)) ? h * 10 + lo : 0;
            else if (e || i) v_m[k] = down ? ((v_m[k] + m - 1) % m) : ((v_m[k] + 1) % m);
        end
        x.id  = NDUT;
        x.v   = c_m;
        x.ca  = (c_m % 60 == 59) && e && !c && !r;
        x.ca2 = (c_m == 3599) && e && !c && !r;
        sb.push_back(x);
        if (r || c) c_m = 0;
        else if (e) c_m = (c_m + 1) % 3600;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit rdn;
        rst = 1'b1; clr = 1'b0; en = 1'b0; inc = 1'b0; ld = 1'b0;
        dh = 4'd0; dl = 4'd0; dn = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) v_m[k] = 0;
        c_m = 0;

        // Reset state, reset overriding load/enable.
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, 3, 3, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Free run through a full MOD=60 revolution and back to 00.
        for (int n = 0; n < 61; n++) cyc(0, 0, 1, 0, 0, 0, 0, 0);

        // Load 23 then step; load 25 (illegal for MOD=24); illegal BCD.
        cyc(0, 0, 0, 0, 1, 2, 3, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 2, 5, 0);
        cyc(0, 0, 0, 0, 1, 1, 12, 0);
        cyc(0, 0, 0, 0, 1, 10, 1, 0);

        // INC-only wrap at 59: CA depends on CA_GATE.
        cyc(0, 0, 0, 0, 1, 5, 9, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Clear beats load and enable at 37.
        cyc(0, 0, 0, 0, 1, 3, 7, 0);
        cyc(0, 1, 1, 0, 1, 3, 7, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Down count across zero, then load 40 and step down.
        cyc(0, 0, 0, 0, 1, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 4, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        rdn = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 15) == 0) rdn = ~rdn;
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 8,
                int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), rdn);
        end

        // Cascade: 3600 enables from 00:00 produce exactly one high carry.
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        hi_ca_cnt = 0;
        for (int n = 0; n < 3600; n++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("HI_CA_ONCE", NDUT, hi_ca_cnt, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cnt_bcd_mod.md
CNT_BCD_MOD -- requirements
Module: cnt_bcd_mod

Interface
REQ-001 Parameter MOD, default 60: count modulus; legal range 2..100; count value runs 0..MOD-1.
REQ-002 Parameter CA_GATE, default 1: 1 = CA qualified by EN; 0 = CA qualified by EN|INC.
REQ-003 Port CLK, input, 1: single clock; all state changes on rising edge.
REQ-004 Port RST, input, 1: reset; synchronous to CLK, active-high.
REQ-005 Port CLR, input, 1: synchronous clear to 0, same effect as RST.
REQ-006 Port EN, input, 1: count enable (cascade/tick input).
REQ-007 Port INC, input, 1: manual single step; advances the count; qualifies CA only when CA_GATE=0.
REQ-008 Port LD, input, 1: synchronous parallel load.
REQ-009 Port DH, input, 4: BCD tens digit for load.
REQ-010 Port DL, input, 4: BCD units digit for load.
REQ-011 Port DN, input, 1: count direction, 1 = down; present only when CNT_BCD_DOWN_EN is defined.
REQ-012 Port QH, output, 4: BCD tens digit, registered.
REQ-013 Port QL, output, 4: BCD units digit, registered.
REQ-014 Port CA, output, 1: terminal-count carry/borrow, combinational, for cascading into the next stage EN.

Function
REQ-015 Count value SHALL be V = 10*QH + QL; QL SHALL always be 0..9; V SHALL always be < MOD.
REQ-016 Priority per edge SHALL be: RST/CLR > LD > step > hold.
REQ-017 Step condition SHALL be (EN | INC) with LD=0; one step per edge regardless of EN and INC both high.
REQ-018 Up step: QL=9 -> QL=0 and QH+1; otherwise QL+1; V=MOD-1 -> V=0 (wrap) in one cycle.
REQ-019 Load SHALL set QH=DH, QL=DL when DL<=9, DH<=9 and 10*DH+DL < MOD; otherwise V SHALL become 0.
REQ-020 Terminal state SHALL be V=MOD-1 when counting up and V=0 when counting down.
REQ-021 CA SHALL equal terminal & qualifier & ~LD & ~CLR & ~RST, with qualifier = EN (CA_GATE=1) or EN|INC (CA_GATE=0).
REQ-022 CA SHALL be high in the same cycle the wrap step is taken (zero latency), so a cascaded stage steps on the same edge.
REQ-023 Without a step condition, QH/QL SHALL hold and CA SHALL be 0.
REQ-024 For MOD<=10, QH SHALL be constant 0.

Reset
REQ-025 RST=1 or CLR=1 at an edge SHALL set QH=0 and QL=0, overriding LD, EN, INC and DN.
REQ-026 During RST/CLR, CA SHALL be 0.
REQ-027 Reset mid-count SHALL take effect on the next edge with no residual carry state; the block holds no state other than QH/QL.

Configuration
REQ-028 Macro CNT_BCD_DOWN_EN defined: DN port exists; DN=1 step: QL=0 -> QL=9 and QH-1, otherwise QL-1; V=0 -> V=MOD-1; CA acts as borrow at V=0.
REQ-029 Macro CNT_BCD_DOWN_EN undefined: no DN port; counter counts up only; logic identical to DN tied 0.
REQ-030 DN change SHALL take effect on the next step; the current value is kept.

Verification
REQ-031 MOD=60, RST then EN=1 for 60 cycles -> 00..59 sequence, CA=1 only at 59, value returns to 00.
REQ-032 MOD=24, LD with DH=2 DL=3 then EN=1 -> 23 with CA=1, next 00; LD 2/5 -> 00.
REQ-033 MOD=60, CA_GATE=1, at 59 with INC=1 EN=0 -> wraps to 00, CA=0; with CA_GATE=0 -> CA=1.
REQ-034 MOD=60 at 37, CLR=1 with LD=1 and EN=1 -> 00, CA=0 that cycle.
REQ-035 CNT_BCD_DOWN_EN, MOD=60, DN=1 from 01 -> 00 (CA=1 when EN=1) -> 59 -> 58; LD 4/0 then step -> 39.
REQ-036 Two instances cascaded (MOD=60, low CA -> high EN) for 3600 EN cycles -> high CA=1 exactly once at 59:59, both wrap to 00:00.
